// File: rtl/power_test.sv
// power_test: switching-load tile of eight alternating-bit rings, one ring
// rotated per enabled ui_in bit so every flop of that bank toggles each edge.
module power_test #(
    parameter int BANK_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int NUM_BANKS = 8;
    localparam logic [BANK_WIDTH-1:0] PATTERN = {(BANK_WIDTH/2){2'b10}};

    logic [BANK_WIDTH-1:0] bank_q [NUM_BANKS];
    logic [BANK_WIDTH-1:0] bank_d [NUM_BANKS];
    logic                  unused_ok;

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_d[i] = ui_in[i] ? {bank_q[i][BANK_WIDTH-2:0], bank_q[i][BANK_WIDTH-1]} : bank_q[i];
            uo_out[i] = bank_q[i][BANK_WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_q[i] <= !rst_n ? PATTERN : bank_d[i];
        end
    end

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, uio_in};
endmodule

// File: tb/tb_power_test.sv
// tb_power_test: vector table for the reset/toggle sequences plus random
// traffic checked against a per-bank enabled-edge parity model.
module tb_power_test;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] par = 8'h00;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] ui;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    power_test dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Expected uo_out bit is 1 after an even number of enabled edges since reset.
    task automatic step(input logic r, input logic [7:0] u, input logic e, input logic [7:0] io);
        @(negedge clk);
        rst_n  = r;
        ui_in  = u;
        ena    = e;
        uio_in = io;
        @(posedge clk);
        par = !r ? 8'h00 : par ^ u;
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] u, input logic [7:0] e, input int n);
        for (int k = 0; k < n; k++) vecs.push_back('{r, u, e});
    endtask

    initial begin
        add(1'b0, 8'hFF, 8'hFF, 3);
        add(1'b1, 8'h00, 8'hFF, 10);
        add(1'b1, 8'h01, 8'hFE, 1); add(1'b1, 8'h01, 8'hFF, 1);
        add(1'b1, 8'h01, 8'hFE, 1); add(1'b1, 8'h01, 8'hFF, 1);
        add(1'b1, 8'hFF, 8'h00, 1); add(1'b1, 8'hFF, 8'hFF, 1);
        add(1'b1, 8'hFF, 8'h00, 1);
        add(1'b0, 8'hFF, 8'hFF, 1);
        add(1'b1, 8'hA5, 8'h5A, 1); add(1'b1, 8'hA5, 8'hFF, 1);
        add(1'b1, 8'hA5, 8'h5A, 1);
        add(1'b1, 8'h00, 8'h5A, 5);
        add(1'b1, 8'hFF, 8'hA5, 1);
        add(1'b0, 8'h00, 8'hFF, 1);
        add(1'b1, 8'hFF, 8'h00, 1);
        add(1'b0, 8'h00, 8'hFF, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].ui, (i < 3) ? 1'b1 : 1'b1, (i < 3) ? 8'hAA : 8'h00);
            chk($sformatf("vec%0d uo_out", i), uo_out, vecs[i].exp);
            chk($sformatf("vec%0d uio_out", i), uio_out, 8'h00);
            chk($sformatf("vec%0d uio_oe", i), uio_oe, 8'h00);
        end

        // ena and uio_in scrambled over a fixed enable pattern must not matter
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h3C ^ 8'(i), 1'($urandom), 8'($urandom));
            chk("ena/uio ignored", uo_out, ~par);
        end

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) != 0), 8'($urandom), 1'($urandom), 8'($urandom));
            chk("random uo_out", uo_out, ~par);
            chk("random uio_out", uio_out | uio_oe, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/power_test.md
Name: power_test

Overview:
- Tiny Tapeout power-characterisation tile with a standard TT user interface.
- Holds 8 banks of flip-flops. Each bank is a rotating alternating-bit ring.
- Each ui_in bit enables one bank. An enabled bank toggles every flop on every clock, so ui_in sets the switching load (0 to 8 banks).
- uo_out exposes one ring bit per bank. This lets the activity be observed and stops synthesis from trimming the flops.

Parameters:
- BANK_WIDTH, default 16: flops per bank. Must be even and >= 2.
- NUM_BANKS, fixed 8: one bank per ui_in / uo_out bit. Not overridable.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  TT design-enable; ignored (no functional effect).
- ui_in  input  8  per-bank toggle enable; bit i enables bank i.
- uio_in  input  8  bidirectional-pin inputs; ignored.
- uo_out  output  8  bit i = MSB (bit BANK_WIDTH-1) of bank i ring.
- uio_out  output  8  constant 0x00.
- uio_oe  output  8  constant 0x00 (all bidirectional pins are inputs).

Behaviour:
- One clock domain. Reset is synchronous, active-low, and sampled on the rising clk edge.
- Reset loads every bank with the alternating pattern bank[j] = (j mod 2): odd bits 1, even bits 0.
  - Resulting MSB = 1, so uo_out = 0xFF from the first edge with rst_n = 0.
  - Reset has priority over ui_in; enables are ignored while rst_n = 0.
  - Reset asserted mid-run restores the pattern at the next edge, whatever the current state.
- Bank i with ui_in[i] = 1 at a rising edge (rst_n = 1) rotates left by one:
  - new[j] = old[j-1] for j >= 1
  - new[0] = old[BANK_WIDTH-1]
  - The pattern is alternating and BANK_WIDTH is even, so every flop of the bank inverts on every enabled edge.
- Bank i with ui_in[i] = 0 holds its value.
- uo_out[i] comes directly from the bank i MSB flop, with no extra pipeline stage.
  - Each enabled edge inverts uo_out[i] (1 -> 0 -> 1 ...).
  - uo_out[i] = 1 after an even number of enabled edges since reset, 0 after an odd number.
- Banks are fully independent. ui_in may change every cycle and only the value sampled at each edge matters.
- No reachable state other than the two alternating phases. All flops must be preserved in synthesis, since each feeds the next in its ring.
- uio_out and uio_oe are constant zero at all times, including during reset.
- ena and uio_in have no effect on any output.
- Gate-level netlist adds vccd1/vssd1 power pins, tied to 1/0 by the harness.

Test Plan:
- Hold rst_n = 0 for 3 edges with ui_in = 0xFF, uio_in = 0xAA, ena = 1 -> uo_out = 0xFF after first edge and stays 0xFF; uio_out = 0x00, uio_oe = 0x00 throughout.
- After reset, ui_in = 0x00 for 10 edges -> uo_out remains 0xFF.
- After reset, ui_in = 0x01 for 4 edges -> uo_out sequence 0xFE, 0xFF, 0xFE, 0xFF.
- After reset, ui_in = 0xFF for 3 edges -> uo_out 0x00, 0xFF, 0x00.
- After reset, ui_in = 0xA5 for 3 edges then ui_in = 0x00 for 5 edges -> uo_out 0x5A, 0xFF, 0x5A, then holds 0x5A.
- With uo_out = 0x00 (ui_in = 0xFF, odd edge count), drive rst_n = 0 for one edge -> uo_out = 0xFF. Toggling ena and uio_in randomly for 20 cycles changes nothing versus the ena = 1, uio_in = 0 run.
